// File: rtl/bin_to_bcd_serial.sv
// Serial binary-to-BCD converter (shift-and-add-3, one bit per clock) feeding the 4-digit display bus.
// Optional build macro SATURATE_EN: an overflowing input shows as 9999 instead of Bin mod 10000.
module bin_to_bcd_serial #(
    parameter int WIDTH = 14,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Bin,
    output logic             Busy,
    output logic             Done,
    output logic             Overflow,
    output logic [3:0]       BCD3,
    output logic [3:0]       BCD2,
    output logic [3:0]       BCD1,
    output logic [3:0]       BCD0
);

    localparam int                 WORK_W   = 16 + WIDTH;
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0]   BCD_MAX  = WIDTH'(9999);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic [WORK_W-1:0] work_q;
    logic [WORK_W-1:0] work_adj_d;
    logic [WORK_W-1:0] work_shift_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_pend_q;
    logic              busy_q;
    logic              done_q;
    logic              ovf_q;
    logic [15:0]       bcd_q;
    logic [15:0]       bcd_load_d;

    function automatic logic [3:0] add3(input logic [3:0] digit);
        logic [3:0] res;
        if (digit >= 4'd5) begin
            res = digit + 4'd3;
        end else begin
            res = digit;
        end
        return res;
    endfunction

    // One double-dabble step: correct every BCD nibble, then shift the whole word left.
    // The bit shifted out of the thousands nibble is dropped, giving Bin mod 10000.
    always_comb begin
        work_adj_d = work_q;
        for (int k = 0; k < 4; k++) begin
            work_adj_d[WIDTH + 4*k +: 4] = add3(work_q[WIDTH + 4*k +: 4]);
        end
        work_shift_d = {work_adj_d[WORK_W-2:0], 1'b0};
    end

    // Value presented to the display when the conversion completes.
    always_comb begin
`ifdef SATURATE_EN
        if (ovf_pend_q) begin
            bcd_load_d = 16'h9999;
        end else begin
            bcd_load_d = work_q[WORK_W-1 -: 16];
        end
`else
        bcd_load_d = work_q[WORK_W-1 -: 16];
`endif
    end

    // Conversion FSM with registered handshake and result outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            work_q     <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= 16'h0000;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (Start) begin
                        work_q     <= {16'h0000, Bin};
                        cnt_q      <= CNT_LOAD;
                        ovf_pend_q <= (Bin > BCD_MAX);
                        state_q    <= ST_SHIFT;
                    end else begin
                        state_q    <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    busy_q <= 1'b1;
                    work_q <= work_shift_d;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    // Busy stays high through the cycle in which Done is visible.
                    busy_q  <= 1'b1;
                    done_q  <= 1'b1;
                    bcd_q   <= bcd_load_d;
                    ovf_q   <= ovf_pend_q;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Overflow = ovf_q;
    assign BCD3     = bcd_q[15:12];
    assign BCD2     = bcd_q[11:8];
    assign BCD1     = bcd_q[7:4];
    assign BCD0     = bcd_q[3:0];

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Self-checking bench for bin_to_bcd_serial: directed handshake cases plus randomized back-to-back conversions.
module tb_bin_to_bcd_serial;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [13:0] Bin;
    logic        Busy;
    logic        Done;
    logic        Overflow;
    logic [3:0]  BCD3, BCD2, BCD1, BCD0;
    logic [15:0] digits;

    int errors = 0;
    int checks = 0;
    logic [15:0] prev_digits = 16'h0000;

`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    bin_to_bcd_serial dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Bin(Bin),
        .Busy(Busy), .Done(Done), .Overflow(Overflow),
        .BCD3(BCD3), .BCD2(BCD2), .BCD1(BCD1), .BCD0(BCD0)
    );

    assign digits = {BCD3, BCD2, BCD1, BCD0};

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits of the value from plain arithmetic.
    function automatic logic [15:0] ref_digits(input int v);
        int m;
        if (SAT && v > 9999) return 16'h9999;
        m = v % 10000;
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic run_conv(input int v, input string tag);
        int  lat;
        int  busy_cnt;
        int  hold_bad;
        bit  seen;
        Bin = 14'(v); Start = 1'b1;
        tick();
        Start = 1'b0; Bin = 14'($urandom);
        lat = 0; busy_cnt = 0; hold_bad = 0; seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            tick();
            if (Busy) busy_cnt++;
            if (Done) begin
                seen = 1'b1;
                lat  = c;
            end else if (digits !== prev_digits) begin
                hold_bad++;
            end
        end
        check({tag, "_latency"}, lat, 15);
        check({tag, "_busy_cycles"}, busy_cnt, 15);
        check({tag, "_hold"}, hold_bad, 0);
        check({tag, "_digits"}, digits, ref_digits(v));
        check({tag, "_ovf"}, Overflow, (v > 9999));
        prev_digits = ref_digits(v);
        tick();
        check({tag, "_done_single"}, Done, 1'b0);
        check({tag, "_busy_idle"}, Busy, 1'b0);
    endtask

    initial begin
        int  dones;
        int  hold_bad;
        int  cnt;
        bit  seen;
        int  vals[$];
        logic [15:0] got;

        Reset = 1'b1; Start = 1'b0; Bin = 14'd0;
        tick(); tick();
        Reset = 1'b0;
        check("rst_busy", Busy, 1'b0);
        check("rst_done", Done, 1'b0);
        check("rst_ovf", Overflow, 1'b0);
        check("rst_digits", digits, 16'h0000);

        run_conv(0, "zero");
        run_conv(1234, "v1234");
        run_conv(9999, "v9999");
        run_conv(10000, "v10000");
        run_conv(16383, "v16383");

        // Second Start mid-conversion with a different Bin is ignored.
        Bin = 14'd7777; Start = 1'b1;
        tick();
        Start = 1'b0;
        dones = 0; got = 16'hFFFF;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin
                Start = 1'b1; Bin = 14'd42;
            end else begin
                Start = 1'b0;
            end
            tick();
            if (Done) begin
                dones++;
                got = digits;
            end
        end
        Start = 1'b0;
        check("ignore_done_count", dones, 1);
        check("ignore_digits", got, ref_digits(7777));
        check("ignore_final", digits, ref_digits(7777));
        prev_digits = ref_digits(7777);

        // Reset in the middle of a conversion aborts with no Done.
        run_conv(1234, "pre_abort");
        Bin = 14'd567; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 1; c <= 6; c++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("abort_digits", digits, 16'h0000);
        check("abort_busy", Busy, 1'b0);
        check("abort_ovf", Overflow, 1'b0);
        dones = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (Done || Busy) dones++;
        end
        check("abort_no_done", dones, 0);
        prev_digits = 16'h0000;

        // Reset wins over Start in the same cycle.
        Reset = 1'b1; Start = 1'b1; Bin = 14'd321;
        tick();
        Reset = 1'b0; Start = 1'b0;
        tick();
        check("rst_prio_busy", Busy, 1'b0);

        // Start held high: back-to-back conversions against the reference.
        vals = '{0, 1, 9, 10, 99, 100, 999, 1000, 9998, 9999, 10000, 10001, 16383};
        for (int i = 0; i < 200; i++) vals.push_back(int'($urandom_range(0, 16383)));
        Start = 1'b1; Bin = 14'(vals[0]);
        tick();
        for (int i = 0; i < vals.size(); i++) begin
            Bin = 14'($urandom);
            cnt = 0; seen = 1'b0; hold_bad = 0;
            while (!seen && cnt < 40) begin
                tick();
                cnt++;
                if (Done) seen = 1'b1;
                else if (digits !== prev_digits) hold_bad++;
            end
            check("b2b_latency", cnt, 15);
            check("b2b_hold", hold_bad, 0);
            check("b2b_digits", digits, ref_digits(vals[i]));
            check("b2b_ovf", Overflow, (vals[i] > 9999));
            prev_digits = ref_digits(vals[i]);
            if (i + 1 < vals.size()) begin
                Bin = 14'(vals[i + 1]);
            end else begin
                Start = 1'b0;
            end
            tick();
        end
        Start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
